// File: rtl/fetch_queue.sv
// fetch_queue: PC generator plus a DEPTH-entry prefetch FIFO of {pc, inst}
// pairs. It sits between the asynchronous-read instruction memory and the
// decode stage. Fetch keeps running while decode stalls, until the queue is
// full. A taken-branch redirect flushes the queue and restarts fetch at the
// branch target.
module fetch_queue #(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                       clk,
  input  logic                       Reset,
  output logic [ADDR_W-1:0]          imem_addr,
  output logic                       imem_req,
  input  logic [INST_W-1:0]          imem_data,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       stall,
  output logic                       out_valid,
  output logic [INST_W-1:0]          out_inst,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];

  logic w_pop;
  logic w_push;
  logic w_has_room;
  logic w_not_empty;

  assign w_not_empty = (r_count != '0);
  assign w_has_room  = (r_count < CNT_W'(DEPTH));
  // Popping frees a slot in the same cycle, so a full queue can still fetch.
  assign w_pop       = w_not_empty & ~stall & ~redirect;
  assign w_push      = ~Reset & ~redirect & (w_has_room | w_pop);

  assign imem_addr = r_fetch_pc;
  assign imem_req  = w_push;
  assign out_valid = w_not_empty;
  assign out_inst  = w_not_empty ? r_inst_mem[r_rd_ptr] : '0;
  assign out_pc    = w_not_empty ? r_pc_mem[r_rd_ptr]   : '0;
  assign count     = r_count;

  // Entry storage: captured on push, contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
      r_inst_mem[r_wr_ptr] <= imem_data;
    end
  end

  // PC, pointers and occupancy; reset beats redirect, redirect beats push/pop.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_fetch_pc <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue with hand-computed values.
// Two instances: default RESET_PC, and one near the top of the address space
// to exercise PC wrap.
module tb_fetch_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: RESET_PC = 0
  logic        rst_a;
  logic [63:0] addr_a;
  logic        req_a;
  logic [31:0] data_a;
  logic        redir_a;
  logic [63:0] redir_pc_a;
  logic        stall_a;
  logic        valid_a;
  logic [31:0] inst_a;
  logic [63:0] pc_a;
  logic [2:0]  cnt_a;

  // Instance B: RESET_PC near wrap point
  logic        rst_b;
  logic [63:0] addr_b;
  logic        req_b;
  logic [31:0] data_b;
  logic        redir_b;
  logic [63:0] redir_pc_b;
  logic        stall_b;
  logic        valid_b;
  logic [31:0] inst_b;
  logic [63:0] pc_b;
  logic [2:0]  cnt_b;

  assign data_a = 32'hD280_0000 + addr_a[31:0];
  assign data_b = 32'hD280_0000 + addr_b[31:0];

  fetch_queue u_dut (
    .clk         (clk),
    .Reset       (rst_a),
    .imem_addr   (addr_a),
    .imem_req    (req_a),
    .imem_data   (data_a),
    .redirect    (redir_a),
    .redirect_pc (redir_pc_a),
    .stall       (stall_a),
    .out_valid   (valid_a),
    .out_inst    (inst_a),
    .out_pc      (pc_a),
    .count       (cnt_a)
  );

  fetch_queue #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) u_wrap (
    .clk         (clk),
    .Reset       (rst_b),
    .imem_addr   (addr_b),
    .imem_req    (req_b),
    .imem_data   (data_b),
    .redirect    (redir_b),
    .redirect_pc (redir_pc_b),
    .stall       (stall_b),
    .out_valid   (valid_b),
    .out_inst    (inst_b),
    .out_pc      (pc_b),
    .count       (cnt_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; sample/drive 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_a = 1'b1; redir_a = 1'b0; stall_a = 1'b0; redir_pc_a = '0;
    step();
    rst_a = 1'b0;
  endtask

  initial begin
    rst_b = 1'b1; redir_b = 1'b0; stall_b = 1'b0; redir_pc_b = '0;

    // ---- Test 1: free-running fetch, no stall
    reset_a();
    #1;
    chk("rst_valid", {63'd0, valid_a}, 64'd0);
    chk("rst_count", {61'd0, cnt_a}, 64'd0);
    chk("rst_addr",  addr_a, 64'd0);
    chk("rst_pc",    pc_a, 64'd0);
    chk("rst_inst",  {32'd0, inst_a}, 64'd0);
    chk("rst_req",   {63'd0, req_a}, 64'd1);
    step();
    for (int i = 1; i <= 5; i++) begin
      chk("run_valid", {63'd0, valid_a}, 64'd1);
      chk("run_pc",    pc_a, 64'(4 * (i - 1)));
      chk("run_inst",  {32'd0, inst_a}, {32'd0, 32'hD280_0000 + 32'(4 * (i - 1))});
      chk("run_count", {61'd0, cnt_a}, 64'd1);
      step();
    end

    // ---- Test 2: stall fills queue, then drains in order
    reset_a();
    step();                 // cycle 1
    stall_a = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      chk("fill_count", {61'd0, cnt_a}, 64'(i));
      chk("fill_head",  pc_a, 64'd0);
      step();
    end
    // now back at count=4 state (after the 4th edge count stays 4)
    for (int i = 0; i < 3; i++) begin
      chk("full_count", {61'd0, cnt_a}, 64'd4);
      chk("full_req",   {63'd0, req_a}, 64'd0);
      chk("full_addr",  addr_a, 64'd16);
      chk("full_head",  pc_a, 64'd0);
      step();
    end
    stall_a = 1'b0;
    #1;
    chk("drain_req", {63'd0, req_a}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk("drain_valid", {63'd0, valid_a}, 64'd1);
      chk("drain_pc",    pc_a, 64'(4 * i));
      chk("drain_count", {61'd0, cnt_a}, 64'd4);
      step();
    end

    // ---- Test 3: redirect with 3 entries queued
    reset_a();
    step();                 // cycle 1
    stall_a = 1'b1;
    step(); step();         // cycle 3, count=3
    #1;
    chk("pre_redir_count", {61'd0, cnt_a}, 64'd3);
    redir_a = 1'b1; redir_pc_a = 64'h100; stall_a = 1'b0;
    #1;
    chk("redir_req", {63'd0, req_a}, 64'd0);
    step();
    redir_a = 1'b0;
    #1;
    chk("redir_count", {61'd0, cnt_a}, 64'd0);
    chk("redir_valid", {63'd0, valid_a}, 64'd0);
    chk("redir_addr",  addr_a, 64'h100);
    chk("redir_pc0",   pc_a, 64'd0);
    step();
    chk("redir_hvalid", {63'd0, valid_a}, 64'd1);
    chk("redir_hpc",    pc_a, 64'h100);
    chk("redir_hinst",  {32'd0, inst_a}, {32'd0, 32'hD280_0100});
    chk("redir_hcount", {61'd0, cnt_a}, 64'd1);

    // ---- Test 4: redirect + stall while full
    stall_a = 1'b1;
    step(); step(); step();
    #1;
    chk("full2_count", {61'd0, cnt_a}, 64'd4);
    chk("full2_head",  pc_a, 64'h100);
    redir_a = 1'b1; redir_pc_a = 64'h200;
    #1;
    chk("rs_req", {63'd0, req_a}, 64'd0);
    step();
    redir_a = 1'b0;
    #1;
    chk("rs_count", {61'd0, cnt_a}, 64'd0);
    chk("rs_valid", {63'd0, valid_a}, 64'd0);
    chk("rs_addr",  addr_a, 64'h200);
    step();
    chk("rs_hpc",    pc_a, 64'h200);
    chk("rs_hcount", {61'd0, cnt_a}, 64'd1);
    step();
    chk("rs_hold_pc",    pc_a, 64'h200);
    chk("rs_hold_count", {61'd0, cnt_a}, 64'd2);

    // ---- Test 5: PC wrap and mid-stream reset on instance B
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    #1;
    chk("w_rst_addr",  addr_b, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("w_rst_valid", {63'd0, valid_b}, 64'd0);
    step();
    chk("w_pc0", pc_b, 64'hFFFF_FFFF_FFFF_FFF8);
    step();
    chk("w_pc1", pc_b, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("w_pc2", pc_b, 64'h0);
    chk("w_inst2", {32'd0, inst_b}, {32'd0, 32'hD280_0000});
    step();
    chk("w_pc3", pc_b, 64'h4);
    stall_b = 1'b1;
    step(); step();
    #1;
    chk("w_pre_count", {61'd0, cnt_b}, 64'd3);
    rst_b = 1'b1;
    step();
    chk("w_mid_count", {61'd0, cnt_b}, 64'd0);
    chk("w_mid_valid", {63'd0, valid_b}, 64'd0);
    chk("w_mid_pc",    pc_b, 64'd0);
    chk("w_mid_addr",  addr_b, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("w_mid_req",   {63'd0, req_b}, 64'd0);
    rst_b = 1'b0; stall_b = 1'b0;
    step();
    chk("w_post_pc",    pc_b, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("w_post_count", {61'd0, cnt_b}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
